spi_ss_router: RTL and testbench

SPI_SS_ROUTER -- requirements
Module: spi_ss_router

---
 rtl/spi_ss_router.sv | 189 ++++++++++++++++++
 tb/tb_spi_ss_router.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ss_router.sv
// Queues SPI requests and steers the single SPI master select onto one of NUM_SS active-low slave selects.
// Latency: a request accepted into an empty queue while idle raises spi_wrt two cycles after acceptance.
// Backpressure: req_rdy drops only when the request queue is full; a push and a pop may share a cycle.
// Optional feature macro: SPI_SS_GAP_EN (adds a GAP_CYC-cycle idle gap after each readback).
module spi_ss_router #(
  parameter int NUM_SS     = 5,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYC    = 8,
  localparam int SEL_W     = $clog2(NUM_SS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic [SEL_W-1:0]  req_sel,
  input  logic [DATA_W-1:0] req_data,
  output logic              spi_wrt,
  output logic [DATA_W-1:0] spi_data_out,
  input  logic              spi_done,
  input  logic              spi_ss_n,
  input  logic [DATA_W-1:0] spi_data_in,
  output logic [NUM_SS-1:0] ss_n,
  output logic              rd_vld,
  output logic [SEL_W-1:0]  rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              err_sel
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = SEL_W + DATA_W;
  localparam logic [PTR_W:0] PTR_ONE = 1;

  // Reject parameter sets the queue and select decode cannot support.
`ifdef SPI_SS_GAP_EN
  if (NUM_SS < 2 || NUM_SS > 16 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || GAP_CYC < 1) begin : g_param_check
    $error("spi_ss_router: unsupported parameter set");
  end
`else
  if (NUM_SS < 2 || NUM_SS > 16 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || GAP_CYC < 0) begin : g_param_check
    $error("spi_ss_router: unsupported parameter set");
  end
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE
`ifdef SPI_SS_GAP_EN
    , S_GAP
`endif
  } state_t;

  state_t state, state_nxt;

  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic              fifo_empty, fifo_full, push, pop;
  logic [ENT_W-1:0]  head;
  logic [SEL_W-1:0]  cur_sel;
  logic [DATA_W-1:0] cur_data;
  logic              sel_ok;
  logic              ss_act;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push       = req_vld && !fifo_full;
  assign pop        = (state == S_IDLE) && !fifo_empty;
  assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign req_rdy    = !fifo_full;

  // Queue storage: written on accept, no reset needed since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= {req_sel, req_data};
    end
  end

  // Queue pointers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Current transaction latched at pop; stays stable through CAPTURE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_sel  <= '0;
      cur_data <= '0;
    end else if (pop) begin
      {cur_sel, cur_data} <= head;
    end
  end

  // Readback registers update only on completion while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sel  <= '0;
      rd_data <= '0;
    end else if (state == S_WAIT && spi_done) begin
      rd_sel  <= cur_sel;
      rd_data <= spi_data_in;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

`ifdef SPI_SS_GAP_EN
  localparam int GAP_CW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_CW-1:0] GAP_ONE = 1;
  logic [GAP_CW-1:0] gap_cnt;

  // Gap counter restarts every time the GAP state is entered.
  always_ff @(posedge clk) begin
    if (rst || state != S_GAP) gap_cnt <= '0;
    else                       gap_cnt <= gap_cnt + GAP_ONE;
  end
`endif

  assign sel_ok = int'(cur_sel) < NUM_SS;

  // Next-state and per-state outputs; an out-of-range selector is dropped in ISSUE.
  always_comb begin
    state_nxt = state;
    spi_wrt   = 1'b0;
    err_sel   = 1'b0;
    rd_vld    = 1'b0;
    ss_act    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (sel_ok) begin
          spi_wrt   = 1'b1;
          ss_act    = 1'b1;
          state_nxt = S_WAIT;
        end else begin
          err_sel   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        ss_act = 1'b1;
        if (spi_done) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        ss_act = 1'b1;
        rd_vld = 1'b1;
`ifdef SPI_SS_GAP_EN
        state_nxt = S_GAP;
`else
        state_nxt = S_IDLE;
`endif
      end
`ifdef SPI_SS_GAP_EN
      S_GAP: begin
        if (int'(gap_cnt) == GAP_CYC - 1) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Select demux: only the active slave follows the master select, all others stay high.
  always_comb begin
    ss_n = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (ss_act && int'(cur_sel) == i) ss_n[i] = spi_ss_n;
    end
  end

  assign spi_data_out = cur_data;
  assign busy         = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_spi_ss_router.sv
// Randomized and directed bench for spi_ss_router with a transaction-level reference model.
module tb_spi_ss_router;

  localparam int NUM_SS     = 5;
  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int GAP_CYC    = 8;
  localparam int SEL_W      = 3;
`ifdef SPI_SS_GAP_EN
  localparam int GAP_EFF = GAP_CYC;
`else
  localparam int GAP_EFF = 0;
`endif

  logic              clk, rst;
  logic              req_vld, req_rdy;
  logic [SEL_W-1:0]  req_sel;
  logic [DATA_W-1:0] req_data;
  logic              spi_wrt;
  logic [DATA_W-1:0] spi_data_out;
  logic              spi_done, spi_ss_n;
  logic [DATA_W-1:0] spi_data_in;
  logic [NUM_SS-1:0] ss_n;
  logic              rd_vld;
  logic [SEL_W-1:0]  rd_sel;
  logic [DATA_W-1:0] rd_data;
  logic              busy, err_sel;

  spi_ss_router #(.NUM_SS(NUM_SS), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_sel(req_sel),
    .req_data(req_data), .spi_wrt(spi_wrt), .spi_data_out(spi_data_out), .spi_done(spi_done),
    .spi_ss_n(spi_ss_n), .spi_data_in(spi_data_in), .ss_n(ss_n), .rd_vld(rd_vld),
    .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy), .err_sel(err_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model state ----------------
  int          q_sel[$];
  logic [15:0] q_data[$];
  int          q_acc[$];
  bit          inflight = 0, done_seen = 0, wrt_seen = 0;
  int          inf_sel = 0, issue_cyc = 0, rd_due = -1, pend_sel = 0;
  logic [15:0] pend_data = '0;
  int          exp_rsel = 0;
  logic [15:0] exp_rdata = '0;
  int          free_at = 0, gap_until = 0;
  // logs for the directed literal checks
  int          wrt_cyc_log[$], rd_cyc_log[$], rd_sel_log[$];
  int          err_cnt = 0, wrt_cnt = 0;
  logic [15:0] last_wrt_data = '0, last_rd_data = '0;
  logic [4:0]  last_ss_low = '1;
  // per-cycle scratch
  bit          exp_iss, iss_ok, exp_rv, exp_rdy, exp_busy;
  int          act_sel;
  logic [4:0]  exp_ss;

  // Compare process: expected outputs follow from queue order and timing rules.
  always @(negedge clk) begin
    if (rst) begin
      q_sel.delete(); q_data.delete(); q_acc.delete();
      inflight = 0; done_seen = 0; wrt_seen = 0; rd_due = -1;
      exp_rsel = 0; exp_rdata = '0; free_at = 0; gap_until = 0;
    end else begin
      exp_iss = q_sel.size() > 0 && !inflight && cyc >= q_acc[0] + 2 && cyc >= free_at;
      iss_ok  = exp_iss && q_sel[0] < NUM_SS;
      exp_rv  = (cyc == rd_due);
      if (exp_rv) begin
        exp_rsel  = pend_sel;
        exp_rdata = pend_data;
      end
      act_sel = iss_ok ? q_sel[0] : (inflight ? inf_sel : -1);
      exp_ss  = '1;
      if (act_sel >= 0) exp_ss[act_sel] = spi_ss_n;
      exp_rdy  = (q_sel.size() - (exp_iss ? 1 : 0)) < FIFO_DEPTH;
      exp_busy = q_sel.size() > 0 || inflight || cyc < gap_until;

      chk("spi_wrt", spi_wrt, iss_ok);
      chk("err_sel", err_sel, exp_iss && !iss_ok);
      if (iss_ok) chk("spi_data_out", spi_data_out, q_data[0]);
      chk("ss_n", ss_n, exp_ss);
      chk("rd_vld", rd_vld, exp_rv);
      chk("rd_sel", rd_sel, exp_rsel);
      chk("rd_data", rd_data, exp_rdata);
      chk("req_rdy", req_rdy, exp_rdy);
      chk("busy", busy, exp_busy);

      if (inflight && spi_ss_n == 1'b0) last_ss_low = ss_n;
      if (spi_wrt) begin
        wrt_cnt++;
        wrt_cyc_log.push_back(cyc);
        last_wrt_data = spi_data_out;
        wrt_seen = 1;
      end
      if (err_sel) err_cnt++;
      if (rd_vld) begin
        rd_cyc_log.push_back(cyc);
        rd_sel_log.push_back(int'(rd_sel));
        last_rd_data = rd_data;
      end

      if (exp_iss) begin
        if (iss_ok) begin
          inflight = 1; inf_sel = q_sel[0]; issue_cyc = cyc; done_seen = 0;
        end else begin
          free_at = cyc + 2;
        end
        void'(q_sel.pop_front()); void'(q_data.pop_front()); void'(q_acc.pop_front());
      end
      if (inflight && !done_seen && cyc > issue_cyc && spi_done) begin
        done_seen = 1; rd_due = cyc + 1; pend_sel = inf_sel; pend_data = spi_data_in;
      end
      if (exp_rv) begin
        inflight  = 0;
        free_at   = cyc + 2 + GAP_EFF;
        gap_until = cyc + 1 + GAP_EFF;
      end
      if (req_vld && exp_rdy) begin
        q_sel.push_back(int'(req_sel)); q_data.push_back(req_data); q_acc.push_back(cyc);
      end
    end
  end

  // ---------------- SPI master model ----------------
  bit          hold_done = 0, force_din = 0, noise_en = 0, fast_done = 0, m_busy = 0;
  logic [15:0] forced_val = '0;
  int          m_cnt = 0;
  bit          m_rst;

  always @(posedge clk) begin
    m_rst = rst;
    #1;
    spi_done = 1'b0;
    if (m_rst) begin
      m_busy = 0; spi_ss_n = 1'b1;
    end else if (wrt_seen) begin
      wrt_seen = 0; m_busy = 1; spi_ss_n = 1'b0;
      m_cnt = fast_done ? 0 : $urandom_range(0, 4);
    end else if (m_busy) begin
      if (!hold_done) begin
        if (m_cnt > 0) m_cnt--;
        else begin
          spi_done = 1'b1;
          spi_data_in = force_din ? forced_val : 16'($urandom);
          m_busy = 0;
        end
      end
    end else begin
      spi_ss_n = 1'b1;
      if (noise_en && $urandom_range(0, 7) == 0) begin
        spi_done = 1'b1;
        spi_data_in = 16'($urandom);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input int sel, input logic [15:0] d, output int acc);
    bit ok = 0;
    acc = -1;
    req_vld = 1'b1; req_sel = 3'(sel); req_data = d;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_rdy) begin ok = 1; acc = cyc; break; end
    end
    chk("push_accept", ok, 1'b1);
    @(posedge clk); #1;
    req_vld = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    bit ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy && !m_busy) begin ok = 1; break; end
    end
    chk("wait_idle", ok, 1'b1);
    @(posedge clk); #1;
  endtask

  int acc, n0, r0, e0, w0;

  initial begin
    rst = 1'b1; req_vld = 1'b0; req_sel = '0; req_data = '0;
    spi_done = 1'b0; spi_ss_n = 1'b1; spi_data_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_ss_n", ss_n, 5'h1f);
    chk("rst_spi_wrt", spi_wrt, 0);
    chk("rst_spi_data_out", spi_data_out, 0);
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_rd_sel", rd_sel, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_err_sel", err_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_rdy", req_rdy, 1);
    tick();

    // Single transaction to slave 4
    force_din = 1; forced_val = 16'hBEEF;
    n0 = wrt_cyc_log.size();
    push(4, 16'h1234, acc);
    wait_idle(100);
    chk("t1_latency", wrt_cyc_log[n0] - acc, 2);
    chk("t1_data_out", last_wrt_data, 16'h1234);
    chk("t1_ss_only4", last_ss_low, 5'b01111);
    chk("t1_rd_sel", rd_sel_log[rd_sel_log.size() - 1], 4);
    chk("t1_rd_data", last_rd_data, 16'hBEEF);
    force_din = 0;

    // Queue fills while one transaction is stalled; overflow push dropped
    hold_done = 1;
    n0 = rd_sel_log.size();
    push(4, 16'h0AAA, acc);
    for (int k = 0; k < 4; k++) push(k, 16'(16'h100 + k), acc);
    req_vld = 1'b1; req_sel = 3'd2; req_data = 16'hDEAD;
    @(negedge clk);
    chk("t2_full_rdy", req_rdy, 0);
    @(posedge clk); #1;
    req_vld = 1'b0;
    repeat (3) tick();
    hold_done = 0;
    wait_idle(200);
    chk("t2_rd_count", rd_sel_log.size() - n0, 5);
    chk("t2_first", rd_sel_log[n0], 4);
    for (int k = 0; k < 4; k++) chk("t2_order", rd_sel_log[n0 + 1 + k], k);

    // Out-of-range selector
    e0 = err_cnt; w0 = wrt_cnt;
    push(6, 16'h5555, acc);
    repeat (5) tick();
    chk("t3_err_pulses", err_cnt - e0, 1);
    chk("t3_no_wrt", wrt_cnt - w0, 0);
    push(2, 16'h2222, acc);
    wait_idle(100);
    chk("t3_next_wrt", wrt_cnt - w0, 1);
    chk("t3_next_sel", rd_sel_log[rd_sel_log.size() - 1], 2);

    // Reset during WAIT
    hold_done = 1;
    push(1, 16'h1111, acc);
    for (int i = 0; i < 20; i++) begin
      if (m_busy) break;
      tick();
    end
    repeat (2) tick();
    r0 = rd_cyc_log.size();
    rst = 1'b1;
    tick();
    rst = 1'b0; hold_done = 0;
    @(negedge clk);
    chk("t4_ss_n", ss_n, 5'h1f);
    chk("t4_rd_vld", rd_vld, 0);
    chk("t4_req_rdy", req_rdy, 1);
    chk("t4_busy", busy, 0);
    @(posedge clk); #1;
    repeat (10) tick();
    chk("t4_no_readback", rd_cyc_log.size() - r0, 0);

    // Inter-transaction gap
    fast_done = 1;
    w0 = wrt_cyc_log.size(); r0 = rd_cyc_log.size();
    push(0, 16'hA0A0, acc);
    push(3, 16'hB0B0, acc);
    wait_idle(200);
    chk("t5_gap", wrt_cyc_log[w0 + 1] - rd_cyc_log[r0], GAP_EFF + 2);
    fast_done = 0;

    // Randomized traffic with spurious completions and occasional reset
    noise_en = 1;
    for (int i = 0; i < 1500; i++) begin
      req_vld  = ($urandom_range(0, 2) == 0);
      req_sel  = 3'($urandom_range(0, 7));
      req_data = 16'($urandom);
      rst      = ($urandom_range(0, 299) == 0);
      tick();
    end
    req_vld = 1'b0; rst = 1'b0; noise_en = 0;
    wait_idle(1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
